// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the multi-cycle execute datapath.
//   exec_op_e          - 3-bit operation code (ADD, SUB, AND, ORR, MUL, MLA)
//   exec_state_e       - datapath FSM states (IDLE, MUL, DONE)
//   status_register_t  - NZCV status register, N in the MSB
//   FLAG_N/Z/C/V       - bit positions of each flag in flags_o
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_ORR = 3'd3,
        OP_MUL = 3'd4,
        OP_MLA = 3'd5
    } exec_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } status_register_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/exec_datapath_mc_if.sv
// exec_datapath_mc_if: decode-side handshake, operand/forwarding buses and
// result/status outputs of the execute datapath.
//   slave  modport - used by exec_datapath_mc
//   master modport - used by the decode stage (or a testbench)
interface exec_datapath_mc_if
    import exec_pkg::*;
#(
    parameter int unsigned WORD       = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned NUM_FWD    = 2
) ();

    logic                          valid_i;
    logic                          ready_o;
    logic                          flush_i;
    exec_op_e                      op_i;
    logic                          update_flag_i;
    logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr_i;
    logic [NUM_SRC*WORD-1:0]       src_data_i;
    logic [NUM_FWD-1:0]            fwd_we_i;
    logic [NUM_FWD*ADDR_WIDTH-1:0] fwd_addr_i;
    logic [NUM_FWD*WORD-1:0]       fwd_data_i;
    logic                          result_valid_o;
    logic [WORD-1:0]               result_o;
    logic [3:0]                    flags_o;

    modport slave (
        input  valid_i, flush_i, op_i, update_flag_i,
        input  src_addr_i, src_data_i, fwd_we_i, fwd_addr_i, fwd_data_i,
        output ready_o, result_valid_o, result_o, flags_o
    );

    modport master (
        output valid_i, flush_i, op_i, update_flag_i,
        output src_addr_i, src_data_i, fwd_we_i, fwd_addr_i, fwd_data_i,
        input  ready_o, result_valid_o, result_o, flags_o
    );

endinterface

// File: rtl/operand_forward_mux.sv
// operand_forward_mux: resolves one source operand against NUM_FWD forwarding
// stages. The lowest-index (youngest) matching stage wins; with no match the
// register-file data passes through. Purely combinational.
//   i_src_addr / i_src_data - source register address and register-file data
//   i_fwd_we / i_fwd_addr / i_fwd_data - packed forwarding stage buses
//   o_data - resolved operand
module operand_forward_mux #(
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned WORD       = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0]         i_src_addr,
    input  logic [WORD-1:0]               i_src_data,
    input  logic [NUM_FWD-1:0]            i_fwd_we,
    input  logic [NUM_FWD*ADDR_WIDTH-1:0] i_fwd_addr,
    input  logic [NUM_FWD*WORD-1:0]       i_fwd_data,
    output logic [WORD-1:0]               o_data
);

    // Walk oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        o_data = i_src_data;
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (i_fwd_we[NUM_FWD-1-k] &&
                (i_fwd_addr[(NUM_FWD-1-k)*ADDR_WIDTH +: ADDR_WIDTH] == i_src_addr)) begin
                o_data = i_fwd_data[(NUM_FWD-1-k)*WORD +: WORD];
            end
        end
    end

endmodule

// File: rtl/exec_datapath_mc.sv
// exec_datapath_mc: execute stage with operand forwarding, single-cycle ALU
// ops (ADD/SUB/AND/ORR) and an iterative MUL/MLA retiring MUL_BITS multiplier
// bits per cycle. Owns the NZCV status register.
//   clk_i   - clock
//   reset_i - asynchronous active-low reset
//   bus     - exec_datapath_mc_if.slave: valid/ready/flush handshake, op,
//             operand and forwarding buses, result pulse, result, flags
module exec_datapath_mc
    import exec_pkg::*;
#(
    parameter int unsigned WORD       = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned MUL_BITS   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    exec_datapath_mc_if.slave  bus
);

    localparam int unsigned STEPS = WORD / MUL_BITS;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    exec_state_e       r_state, w_state_nxt;
    status_register_t  r_flags;
    logic [WORD-1:0]   r_result, r_acc, r_mcand, r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_result_valid, r_upd;

    logic [WORD-1:0]   w_opnd [NUM_SRC];
    logic [WORD-1:0]   w_a, w_b, w_c;
    logic [WORD:0]     w_sum, w_diff;
    logic [WORD-1:0]   w_alu_res, w_pp, w_acc_nxt;
    logic              w_alu_c, w_alu_v, w_arith;
    logic              w_ready, w_accept, w_is_mul, w_last;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        operand_forward_mux #(
            .NUM_FWD    (NUM_FWD),
            .WORD       (WORD),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_fwd (
            .i_src_addr (bus.src_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_src_data (bus.src_data_i[s*WORD +: WORD]),
            .i_fwd_we   (bus.fwd_we_i),
            .i_fwd_addr (bus.fwd_addr_i),
            .i_fwd_data (bus.fwd_data_i),
            .o_data     (w_opnd[s])
        );
    end

    assign w_a = w_opnd[0];
    assign w_b = w_opnd[1];
    if (NUM_SRC > 2) begin : g_acc_src
        assign w_c = w_opnd[2];
    end else begin : g_no_acc_src
        assign w_c = '0;
    end

    // ALU: SUB as A + ~B + 1 so the carry out is NOT borrow.
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + (WORD+1)'(1);

    always_comb begin
        w_alu_res = w_sum[WORD-1:0];
        w_alu_c   = w_sum[WORD];
        w_alu_v   = (w_a[WORD-1] == w_b[WORD-1]) && (w_sum[WORD-1] != w_a[WORD-1]);
        w_arith   = 1'b1;
        unique case (bus.op_i)
            OP_SUB: begin
                w_alu_res = w_diff[WORD-1:0];
                w_alu_c   = w_diff[WORD];
                w_alu_v   = (w_a[WORD-1] != w_b[WORD-1]) && (w_diff[WORD-1] != w_a[WORD-1]);
            end
            OP_AND: begin
                w_alu_res = w_a & w_b;
                w_arith   = 1'b0;
            end
            OP_ORR: begin
                w_alu_res = w_a | w_b;
                w_arith   = 1'b0;
            end
            default: ;
        endcase
    end

    // Multiplicand is pre-shifted each step, so the partial product is
    // already aligned to the current multiplier digit position.
    assign w_pp      = r_mcand * WORD'(r_mplier[MUL_BITS-1:0]);
    assign w_acc_nxt = r_acc + w_pp;
    assign w_last    = (r_cnt == CNT_W'(STEPS - 1));
    assign w_is_mul  = (bus.op_i == OP_MUL) || (bus.op_i == OP_MLA);

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ready  = 1'b1;
                w_accept = bus.valid_i && !bus.flush_i;
                if (w_accept && w_is_mul) w_state_nxt = ST_MUL;
            end
            ST_MUL: begin
                if (bus.flush_i)  w_state_nxt = ST_IDLE;
                else if (w_last)  w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // The multiply result and its flags are registered on the edge entering
    // DONE, so the DONE cycle is exactly the result_valid_o cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_acc          <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_cnt          <= '0;
            r_upd          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_flags        <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_accept) begin
                r_upd <= bus.update_flag_i;
                if (w_is_mul) begin
                    r_mcand  <= w_a;
                    r_mplier <= w_b;
                    r_acc    <= (bus.op_i == OP_MLA) ? w_c : '0;
                    r_cnt    <= '0;
                end else begin
                    r_result       <= w_alu_res;
                    r_result_valid <= 1'b1;
                    if (bus.update_flag_i) begin
                        r_flags.n <= w_alu_res[WORD-1];
                        r_flags.z <= (w_alu_res == '0);
                        if (w_arith) begin
                            r_flags.c <= w_alu_c;
                            r_flags.v <= w_alu_v;
                        end
                    end
                end
            end else if ((r_state == ST_MUL) && !bus.flush_i) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << MUL_BITS;
                r_mplier <= r_mplier >> MUL_BITS;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result       <= w_acc_nxt;
                    r_result_valid <= 1'b1;
                    if (r_upd) begin
                        r_flags.n <= w_acc_nxt[WORD-1];
                        r_flags.z <= (w_acc_nxt == '0);
                    end
                end
            end
        end
    end

    assign bus.ready_o        = w_ready;
    assign bus.result_valid_o = r_result_valid;
    assign bus.result_o       = r_result;
    assign bus.flags_o[FLAG_N] = r_flags.n;
    assign bus.flags_o[FLAG_Z] = r_flags.z;
    assign bus.flags_o[FLAG_C] = r_flags.c;
    assign bus.flags_o[FLAG_V] = r_flags.v;

endmodule

// File: tb/tb_exec_datapath_mc.sv
// tb_exec_datapath_mc: directed self-checking bench for exec_datapath_mc.
module tb_exec_datapath_mc;
    import exec_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    exec_datapath_mc_if #(
        .WORD       (32),
        .ADDR_WIDTH (4),
        .NUM_SRC    (3),
        .NUM_FWD    (2)
    ) bus ();

    exec_datapath_mc #(
        .WORD       (32),
        .ADDR_WIDTH (4),
        .NUM_SRC    (3),
        .NUM_FWD    (2),
        .MUL_BITS   (2)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int unsigned s, input logic [3:0] a, input logic [31:0] d);
        bus.src_addr_i[s*4 +: 4]   = a;
        bus.src_data_i[s*32 +: 32] = d;
    endtask

    task automatic set_fwd(input int unsigned f, input logic we, input logic [3:0] a, input logic [31:0] d);
        bus.fwd_we_i[f]             = we;
        bus.fwd_addr_i[f*4 +: 4]    = a;
        bus.fwd_data_i[f*32 +: 32]  = d;
    endtask

    task automatic set_op(input exec_op_e op, input logic upd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c);
        bus.op_i          = op;
        bus.update_flag_i = upd;
        set_src(0, 4'd1, a);
        set_src(1, 4'd2, b);
        set_src(2, 4'd4, c);
    endtask

    initial begin
        int low;
        int pulse_at;
        int pulses;
        logic [31:0] pulse_res;
        logic seen;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.valid_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.op_i          = OP_ADD;
        bus.update_flag_i = 1'b0;
        bus.src_addr_i    = '0;
        bus.src_data_i    = '0;
        bus.fwd_we_i      = '0;
        bus.fwd_addr_i    = '0;
        bus.fwd_data_i    = '0;

        // Reset state
        step();
        check("rst_ready",  32'(bus.ready_o), 32'd1);
        check("rst_rvalid", 32'(bus.result_valid_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_flags",  32'(bus.flags_o), 32'd0);
        rst_n = 1'b1;
        step();

        // Forwarding priority, back-to-back ADDs
        bus.op_i = OP_ADD;
        bus.update_flag_i = 1'b0;
        set_src(0, 4'd3, 32'h11);
        set_src(1, 4'd5, 32'h1);
        set_src(2, 4'd0, 32'h0);
        set_fwd(0, 1'b1, 4'd3, 32'hAA);
        set_fwd(1, 1'b1, 4'd3, 32'hBB);
        bus.valid_i = 1'b1;
        step();
        check("fwd_both_valid", 32'(bus.result_valid_o), 32'd1);
        check("fwd_both",       bus.result_o, 32'hAB);
        check("fwd_ready",      32'(bus.ready_o), 32'd1);
        bus.fwd_we_i = 2'b10;
        step();
        check("fwd_wb", bus.result_o, 32'hBC);
        bus.fwd_we_i = 2'b00;
        step();
        check("fwd_none", bus.result_o, 32'h12);

        // ADD overflow flags then SUB zero flags, back to back
        set_op(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0);
        step();
        check("add_ovf_res",   bus.result_o, 32'h8000_0000);
        check("add_ovf_flags", 32'(bus.flags_o), 32'b1001);
        set_op(OP_SUB, 1'b1, 32'd5, 32'd5, 32'h0);
        step();
        check("sub_zero_valid", 32'(bus.result_valid_o), 32'd1);
        check("sub_zero_res",   bus.result_o, 32'd0);
        check("sub_zero_flags", 32'(bus.flags_o), 32'b0110);
        bus.valid_i = 1'b0;
        step();
        check("idle_no_valid", 32'(bus.result_valid_o), 32'd0);

        // MLA timing with a second op held on valid_i
        set_op(OP_MLA, 1'b0, 32'd7, 32'd6, 32'd100);
        bus.valid_i = 1'b1;
        step();
        set_op(OP_ADD, 1'b0, 32'd2, 32'd3, 32'd0);
        low = 0; pulse_at = 0; pulse_res = '0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.result_valid_o) begin
                pulse_at  = k;
                pulse_res = bus.result_o;
            end
            if (bus.ready_o) break;
            low++;
            step();
        end
        check("mla_ready_low", 32'(low), 32'd17);
        check("mla_pulse_cyc", 32'(pulse_at), 32'd17);
        check("mla_result",    pulse_res, 32'd142);
        step();
        check("held_op_valid", 32'(bus.result_valid_o), 32'd1);
        check("held_op_res",   bus.result_o, 32'd5);
        check("mla_flags_kept", 32'(bus.flags_o), 32'b0110);
        bus.valid_i = 1'b0;

        // Set C and V, then MUL wrap must hold them
        set_op(OP_ADD, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0);
        bus.valid_i = 1'b1;
        step();
        check("cv_setup_flags", 32'(bus.flags_o), 32'b0111);
        set_op(OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        step();
        bus.valid_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.result_valid_o) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("mul_done_seen", 32'(seen), 32'd1);
        check("mul_wrap_res",  bus.result_o, 32'h1);
        check("mul_wrap_flags", 32'(bus.flags_o), 32'b0011);

        // Flush at cycle 8 of a MUL, with a simultaneous valid op
        set_op(OP_MUL, 1'b1, 32'd0, 32'd5, 32'h0);
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        for (int k = 0; k < 7; k++) step();
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        set_op(OP_ADD, 1'b1, 32'd1, 32'd1, 32'h0);
        step();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        check("flush_ready",  32'(bus.ready_o), 32'd1);
        check("flush_rvalid", 32'(bus.result_valid_o), 32'd0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.result_valid_o) pulses++;
        end
        check("flush_no_pulse", 32'(pulses), 32'd0);
        check("flush_flags",    32'(bus.flags_o), 32'b0011);
        check("flush_result",   bus.result_o, 32'h1);

        // Flush with valid in IDLE: not accepted
        set_op(OP_ADD, 1'b1, 32'd0, 32'd0, 32'h0);
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        step();
        check("idle_flush_rvalid", 32'(bus.result_valid_o), 32'd0);
        check("idle_flush_flags",  32'(bus.flags_o), 32'b0011);

        // Flush the cycle after a single-cycle accept: result still retires
        bus.flush_i = 1'b0;
        set_op(OP_ADD, 1'b0, 32'd2, 32'd2, 32'h0);
        step();
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b0;
        check("late_flush_rvalid", 32'(bus.result_valid_o), 32'd1);
        check("late_flush_res",    bus.result_o, 32'd4);
        step();
        bus.flush_i = 1'b0;
        check("late_flush_after", 32'(bus.result_valid_o), 32'd0);

        // Reset at cycle 5 of a MUL
        set_op(OP_MUL, 1'b1, 32'd3, 32'd3, 32'h0);
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("pre_rst_busy", 32'(bus.ready_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mrst_ready",  32'(bus.ready_o), 32'd1);
        check("mrst_rvalid", 32'(bus.result_valid_o), 32'd0);
        check("mrst_result", bus.result_o, 32'd0);
        check("mrst_flags",  32'(bus.flags_o), 32'd0);
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.result_valid_o) pulses++;
        end
        check("mrst_no_pulse", 32'(pulses), 32'd0);
        check("mrst_idle",     32'(bus.ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
